// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Misses refill a whole line word-by-word; stores always go straight to memory.
module dcache #(
   parameter int LINES = 4,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        LoadM,
   input  logic        MemWrite,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        dhit,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  dbg_state
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REFILL = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [31:0] LINE_MASK = ~((32'd1 << (OFF_W + 2)) - 32'd1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   // Memory handshake: a word moves on every cycle where mem_req and mem_ready
   // are both 1; mem_req/mem_we/mem_addr/mem_wdata hold until that cycle.

   logic [1:0]       state_q, state_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [LINES-1:0] valid_q, valid_d;

   logic [31:0]      data_q [LINES*WORDS];
   logic [TAG_W-1:0] tag_q  [LINES];

   logic [OFF_W-1:0] req_off, lat_off;
   logic [IDX_W-1:0] req_idx, lat_idx;
   logic [TAG_W-1:0] req_tag, lat_tag;
   logic             req_hit, lat_hit;

   logic                   arr_we;
   logic [IDX_W+OFF_W-1:0] arr_waddr;
   logic [31:0]            arr_wdata;
   logic                   tag_we;

   assign req_off = ALUOut[OFF_W+1:2];
   assign req_idx = ALUOut[OFF_W+IDX_W+1:OFF_W+2];
   assign req_tag = ALUOut[31:OFF_W+IDX_W+2];
   assign lat_off = addr_q[OFF_W+1:2];
   assign lat_idx = addr_q[OFF_W+IDX_W+1:OFF_W+2];
   assign lat_tag = addr_q[31:OFF_W+IDX_W+2];

   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      valid_d   = valid_q;
      dhit      = 1'b0;
      ReadData  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      arr_we    = 1'b0;
      arr_waddr = '0;
      arr_wdata = '0;
      tag_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            dhit = 1'b1;
            if (MemWrite) begin
               dhit    = 1'b0;
               addr_d  = ALUOut & WORD_MASK;
               wdata_d = WriteData;
               state_d = S_WRITE;
            end else if (LoadM) begin
               if (req_hit) begin
                  ReadData = data_q[{req_idx, req_off}];
               end else begin
                  // The victim line is dropped up front so an aborted refill never looks valid.
                  dhit             = 1'b0;
                  addr_d           = ALUOut & LINE_MASK;
                  cnt_d            = '0;
                  valid_d[req_idx] = 1'b0;
                  state_d          = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = addr_q | (32'(cnt_q) << 2);
            if (mem_ready) begin
               arr_we    = 1'b1;
               arr_waddr = {lat_idx, cnt_q};
               arr_wdata = mem_rdata;
               cnt_d     = cnt_q + OFF_W'(1);
               if (cnt_q == OFF_W'(WORDS - 1)) begin
                  tag_we           = 1'b1;
                  valid_d[lat_idx] = 1'b1;
                  state_d          = S_IDLE;
               end
            end
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_ready) begin
               if (lat_hit) begin
                  arr_we    = 1'b1;
                  arr_waddr = {lat_idx, lat_off};
                  arr_wdata = wdata_q;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // One-cycle acknowledge lets the core retire the store without reissuing it.
            dhit    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) data_q[arr_waddr] <= arr_wdata;
      if (tag_we) tag_q[lat_idx] <= lat_tag;
   end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: transaction-level cache/memory model drives
// per-cycle expectations that one compare process checks against the DUT.
module tb_dcache;

   logic        clk = 1'b0;
   logic        reset;
   logic        LoadM, MemWrite;
   logic [31:0] ALUOut, WriteData, ReadData;
   logic        dhit, mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  dbg_state;

   dcache #(.LINES(4), .WORDS(4)) dut (
      .clk(clk), .reset(reset), .LoadM(LoadM), .MemWrite(MemWrite),
      .ALUOut(ALUOut), .WriteData(WriteData), .ReadData(ReadData), .dhit(dhit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Backing memory seen by the DUT, and the reference memory the model owns.
   logic [31:0] bmem    [1024];
   logic [31:0] ref_mem [1024];
   assign mem_rdata = bmem[mem_addr[11:2]];
   always @(posedge clk)
      if (mem_req && mem_ready && mem_we) bmem[mem_addr[11:2]] <= mem_wdata;

   // Cache model: which tag each index holds; cached data always equals ref_mem.
   bit          mvalid [4];
   logic [25:0] mtag   [4];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle expectations written by the drivers, read by the compare process.
   bit          chk_en = 0;
   logic        exp_dhit, exp_req, exp_we;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   int          low_cnt;
   logic [31:0] exp_q[$];
   logic [31:0] rd_smp;

   task automatic set_exp(input logic d, input logic rq, input logic we,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
      exp_dhit = d; exp_req = rq; exp_we = we;
      exp_addr = a; exp_wdata = wd; exp_rdata = rd;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dhit", 32'(dhit), 32'(exp_dhit));
         chk("ReadData", ReadData, exp_rdata);
         chk("mem_req", 32'(mem_req), 32'(exp_req));
         if (exp_req) begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", mem_addr, exp_addr);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
         end
         if (!dhit) low_cnt++;
         if (mem_req && mem_ready) exp_q.push_back(mem_addr);
      end
   end

   task automatic step();
      @(negedge clk);
      rd_smp = ReadData;
      @(posedge clk);
      #1;
   endtask

   int mode;
   int wc;
   task automatic pick_ready(output logic r);
      case (mode)
         0: r = 1'b1;
         1: begin wc++; r = (wc == 3); if (r) wc = 0; end
         default: begin wc++; r = (wc >= 3) ? 1'b1 : 1'(($urandom_range(0, 1))); if (r) wc = 0; end
      endcase
   endtask

   task automatic start_txn();
      low_cnt = 0;
      exp_q.delete();
      wc = 0;
   endtask

   task automatic run_load(input logic [31:0] a);
      logic [31:0] w;
      int          idx;
      bit          hit;
      logic        r;
      w   = {a[31:2], 2'b00};
      idx = int'(a[5:4]);
      hit = mvalid[idx] && (mtag[idx] == a[31:6]);
      start_txn();
      LoadM = 1'b1; MemWrite = 1'b0; ALUOut = a; WriteData = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      if (!hit) begin
         set_exp(0, 0, 0, 0, 0, 0);
         step();
         for (int k = 0; k < 4; k++) begin
            do begin
               pick_ready(r);
               mem_ready = r;
               set_exp(0, 1, 0, (w & 32'hFFFF_FFF0) + 32'(4 * k), 0, 0);
               step();
            end while (!r);
         end
         mvalid[idx] = 1;
         mtag[idx]   = a[31:6];
         mem_ready   = 1'($urandom_range(0, 1));
      end
      set_exp(1, 0, 0, 0, 0, ref_mem[w[11:2]]);
      step();
      LoadM = 1'b0;
   endtask

   task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic both);
      logic [31:0] w;
      logic        r;
      w = {a[31:2], 2'b00};
      start_txn();
      MemWrite = 1'b1; LoadM = both; ALUOut = a; WriteData = d;
      mem_ready = 1'($urandom_range(0, 1));
      set_exp(0, 0, 0, 0, 0, 0);
      step();
      do begin
         pick_ready(r);
         mem_ready = r;
         set_exp(0, 1, 1, w, d, 0);
         step();
      end while (!r);
      ref_mem[w[11:2]] = d;
      mem_ready = 1'($urandom_range(0, 1));
      set_exp(1, 0, 0, 0, 0, 0);
      step();
      MemWrite = 1'b0; LoadM = 1'b0;
   endtask

   task automatic run_idle();
      LoadM = 1'b0; MemWrite = 1'b0; ALUOut = $urandom; WriteData = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      set_exp(1, 0, 0, 0, 0, 0);
      step();
   endtask

   task automatic check_beats(input string nm, input logic [31:0] base);
      chk({nm, " beats"}, 32'(exp_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < exp_q.size(); k++)
         chk({nm, " beat addr"}, exp_q[k], base + 32'(4 * k));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         bmem[i]    = 32'hC0DE_0000 | 32'(i << 2);
         ref_mem[i] = 32'hC0DE_0000 | 32'(i << 2);
      end
      for (int i = 0; i < 4; i++) mvalid[i] = 0;
      reset = 1'b0; LoadM = 1'b0; MemWrite = 1'b0; ALUOut = '0; WriteData = '0; mem_ready = 1'b0;
      mode = 0; wc = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset dhit", 32'(dhit), 32'd1);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      chk("reset ReadData", ReadData, 32'd0);
      reset = 1'b1;
      chk_en = 1;
      run_idle();

      run_load(32'h100);
      chk("load 0x100 stall", 32'(low_cnt), 32'd5);
      chk("load 0x100 data", rd_smp, 32'hC0DE_0100);
      check_beats("load 0x100", 32'h100);

      run_load(32'h10C);
      chk("load 0x10C stall", 32'(low_cnt), 32'd0);
      chk("load 0x10C data", rd_smp, 32'hC0DE_010C);
      chk("load 0x10C beats", 32'(exp_q.size()), 32'd0);

      run_store(32'h104, 32'hDEAD_BEEF, 1'b0);
      chk("store 0x104 stall", 32'(low_cnt), 32'd2);
      chk("store 0x104 beats", 32'(exp_q.size()), 32'd1);
      run_load(32'h104);
      chk("load 0x104 stall", 32'(low_cnt), 32'd0);
      chk("load 0x104 data", rd_smp, 32'hDEAD_BEEF);

      run_store(32'h400, 32'h1234_5678, 1'b1);
      chk("store 0x400 stall", 32'(low_cnt), 32'd2);
      chk("store 0x400 mem", bmem[32'h400 >> 2], 32'h1234_5678);
      run_load(32'h100);
      chk("reload 0x100 stall", 32'(low_cnt), 32'd0);
      chk("reload 0x100 data", rd_smp, 32'hC0DE_0100);

      mode = 1;
      run_load(32'h200);
      chk("slow load 0x200 stall", 32'(low_cnt), 32'd13);
      chk("slow load 0x200 data", rd_smp, 32'hC0DE_0200);
      check_beats("slow load 0x200", 32'h200);

      // Reset during the third refill word of 0x100.
      mode = 0;
      start_txn();
      LoadM = 1'b1; MemWrite = 1'b0; ALUOut = 32'h100; mem_ready = 1'b1;
      set_exp(0, 0, 0, 0, 0, 0);
      step();
      for (int k = 0; k < 2; k++) begin
         set_exp(0, 1, 0, 32'h100 + 32'(4 * k), 0, 0);
         step();
      end
      set_exp(0, 1, 0, 32'h108, 0, 0);
      @(negedge clk);
      #1;
      chk_en = 0;
      LoadM = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrst mem_req", 32'(mem_req), 32'd0);
      chk("midrst dhit", 32'(dhit), 32'd1);
      chk("midrst mem_addr", mem_addr, 32'd0);
      chk("midrst ReadData", ReadData, 32'd0);
      for (int i = 0; i < 4; i++) mvalid[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      chk_en = 1;
      run_load(32'h100);
      chk("post-reset 0x100 stall", 32'(low_cnt), 32'd5);
      chk("post-reset 0x100 data", rd_smp, 32'hC0DE_0100);
      check_beats("post-reset 0x100", 32'h100);

      repeat (400) begin
         logic [31:0] a;
         int          op;
         mode = $urandom_range(0, 2);
         op   = $urandom_range(0, 9);
         a    = 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
         if (op < 5)       run_load(a);
         else if (op < 8)  run_store(a, $urandom, 1'($urandom_range(0, 1)));
         else              run_idle();
      end
      run_idle();
      chk_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

endmodule
